// File: rtl/div_unit.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU: one quotient bit per cycle, sign fix-up and RISC-V special cases.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero, signed overflow and |op1| < |op2| skip the iterative phase.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      div_op,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic [XLEN-1:0] op1_q, op1_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            is_rem_q, is_rem_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic            div0_q, div0_d;
  logic            ovf_q, ovf_d;

  // Operand decode, only meaningful while idle
  logic            in_signed, in_neg1, in_neg2, in_div0, in_ovf;
  logic [XLEN-1:0] in_abs1, in_abs2;

  always_comb begin
    in_signed = ~div_op[0];
    in_neg1   = in_signed & op1[XLEN-1];
    in_neg2   = in_signed & op2[XLEN-1];
    in_abs1   = in_neg1 ? -op1 : op1;
    in_abs2   = in_neg2 ? -op2 : op2;
    in_div0   = (op2 == '0);
    in_ovf    = in_signed && (op1 == MIN_NEG) && (op2 == '1);
  end

  // One restoring step: shift in the next dividend bit (held in quo_q's MSB) and trial-subtract
  logic [XLEN:0]   shifted, diff;
  logic [XLEN-1:0] rem_step, quo_step;
  logic            step_ok;

  always_comb begin
    shifted  = {rem_q, quo_q[XLEN-1]};
    diff     = shifted - {1'b0, dvsr_q};
    step_ok  = ~diff[XLEN];
    rem_step = step_ok ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_step = {quo_q[XLEN-2:0], step_ok};
  end

  function automatic logic [XLEN-1:0] fix_result(
    input logic            is_rem,
    input logic            q_neg,
    input logic            r_neg,
    input logic            div0,
    input logic            ovf,
    input logic [XLEN-1:0] dividend,
    input logic [XLEN-1:0] q,
    input logic [XLEN-1:0] r
  );
    logic [XLEN-1:0] res;
    if (div0)        res = is_rem ? dividend : '1;
    else if (ovf)    res = is_rem ? '0 : MIN_NEG;
    else if (is_rem) res = r_neg ? -r : r;
    else             res = q_neg ? -q : q;
    return res;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    op1_d    = op1_q;
    result_d = result_q;
    is_rem_d = is_rem_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    div0_d   = div0_q;
    ovf_d    = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          is_rem_d = div_op[1];
          qneg_d   = in_neg1 ^ in_neg2;
          rneg_d   = in_neg1;
          div0_d   = in_div0;
          ovf_d    = in_ovf;
          op1_d    = op1;
          dvsr_d   = in_abs2;
          quo_d    = in_abs1;
          rem_d    = '0;
          cnt_d    = CW'(XLEN - 1);
          state_d  = S_CALC;
`ifdef DIV_EARLY_OUT_EN
          if (in_div0 || in_ovf || (in_abs1 < in_abs2)) begin
            state_d  = S_DONE;
            result_d = fix_result(div_op[1], in_neg1 ^ in_neg2, in_neg1, in_div0, in_ovf,
                                  op1, '0, in_abs1);
          end
`endif
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          rem_d = rem_step;
          quo_d = quo_step;
          if (cnt_q == '0) begin
            state_d  = S_DONE;
            result_d = fix_result(is_rem_q, qneg_q, rneg_q, div0_q, ovf_q, op1_q, quo_step, rem_step);
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      op1_q    <= '0;
      result_q <= '0;
      is_rem_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      op1_q    <= op1_d;
      result_q <= result_d;
      is_rem_q <= is_rem_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
      ovf_q    <= ovf_d;
    end
  end

  // A flush arriving in the done cycle suppresses the pulse
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE) && !flush;
  assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected results/probes, a negedge monitor compares.
`timescale 1ns/1ps
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [1:0]  div_op;
  logic [31:0] op1, op2;
  logic        busy, done;
  logic [31:0] result;

  always #5 clk = ~clk;

  div_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .div_op (div_op),
    .op1    (op1),
    .op2    (op2),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;
  localparam int LAT_FULL = 32;
`ifdef DIV_EARLY_OUT_EN
  localparam int LAT_FAST = 0;
`else
  localparam int LAT_FAST = 32;
`endif

  typedef struct {
    string       name;
    logic [31:0] exp;
    int          lat;
    int          t0;
  } sb_t;

  typedef struct {
    string       name;
    int          kind;   // 0 busy, 1 done, 2 result
    logic [31:0] exp;
  } pr_t;

  sb_t sb_q[$];
  pr_t pr_q[$];
  sb_t e;
  pr_t p;

  int edge_cnt = 0;
  int n_chk    = 0;
  int n_fail   = 0;
  bit end_req  = 1'b0;
  logic [31:0] act;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Monitor: the only process that compares and counts
  always @(negedge clk) begin
    while (pr_q.size() > 0) begin
      p = pr_q.pop_front();
      case (p.kind)
        0:       act = {31'b0, busy};
        1:       act = {31'b0, done};
        default: act = result;
      endcase
      n_chk++;
      if (act !== p.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", p.name, act, p.exp);
      end
    end
    if (done) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 result=%h expected no done", result);
      end else begin
        e = sb_q.pop_front();
        $display("done %s result=%h latency=%0d", e.name, result, edge_cnt - e.t0);
        n_chk++;
        if (result !== e.exp) begin
          n_fail++;
          $display("FAIL %s_result: got %h expected %h", e.name, result, e.exp);
        end
        n_chk++;
        if ((edge_cnt - e.t0) != e.lat) begin
          n_fail++;
          $display("FAIL %s_latency: got %0d expected %0d", e.name, edge_cnt - e.t0, e.lat);
        end
      end
    end
    if (end_req) begin
      n_chk++;
      if (sb_q.size() != 0) begin
        n_fail++;
        $display("FAIL missing_done: got %0d outstanding expected 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end
    if (edge_cnt > 20000) begin
      $display("FAIL watchdog: got %0d cycles expected under 20000", edge_cnt);
      $fatal(1, "watchdog expired");
    end
  end

  task automatic probe(input string n, input int k, input logic [31:0] v);
    pr_t t;
    t.name = n;
    t.kind = k;
    t.exp  = v;
    pr_q.push_back(t);
  endtask

  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    div_op = op;
    op1    = a;
    op2    = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic expect_done(input string n, input logic [31:0] v, input int lat);
    sb_t t;
    t.name = n;
    t.exp  = v;
    t.lat  = lat;
    t.t0   = edge_cnt;
    sb_q.push_back(t);
  endtask

  task automatic do_op(input string n, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] v, input int lat);
    launch(op, a, b);
    expect_done(n, v, lat);
    repeat (lat + 3) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    div_op = 2'b00;
    op1    = '0;
    op2    = '0;
    repeat (3) @(posedge clk);
    #1;
    probe("reset_busy", 0, 32'd0);
    probe("reset_done", 1, 32'd0);
    probe("reset_result", 2, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_op("div_100_7",     OP_DIV,  32'd100,      32'd7,        32'd14,       LAT_FULL);
    do_op("rem_100_7",     OP_REM,  32'd100,      32'd7,        32'd2,        LAT_FULL);
    do_op("rem_m7_2",      OP_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, LAT_FULL);
    do_op("div_m7_2",      OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, LAT_FULL);
    do_op("div_by_zero",   OP_DIV,  32'h00001234, 32'd0,        32'hFFFFFFFF, LAT_FAST);
    do_op("remu_by_zero",  OP_REMU, 32'h00001234, 32'd0,        32'h00001234, LAT_FAST);
    do_op("div_overflow",  OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT_FAST);
    do_op("rem_overflow",  OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, LAT_FAST);
    do_op("div_5_m9",      OP_DIV,  32'd5,        32'hFFFFFFF7, 32'h00000000, LAT_FAST);
    do_op("rem_m5_9",      OP_REM,  32'hFFFFFFFB, 32'd9,        32'hFFFFFFFB, LAT_FAST);
    do_op("remu_max_16",   OP_REMU, 32'hFFFFFFFF, 32'h10,       32'h0000000F, LAT_FULL);
    do_op("divu_max_1",    OP_DIVU, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, LAT_FULL);

    // Flush ten cycles into CALC: no done, result keeps the last value
    launch(OP_DIV, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    probe("flush_busy", 0, 32'd0);
    probe("flush_result", 2, 32'hFFFFFFFF);
    repeat (40) @(posedge clk);
    #1;

    // New op after flush; a second start while busy must be dropped
    launch(OP_DIV, 32'd100, 32'd7);
    expect_done("div_after_flush", 32'd14, LAT_FULL);
    repeat (5) @(posedge clk);
    #1;
    launch(OP_REMU, 32'hFFFFFFFF, 32'h10);
    probe("ignored_start_busy", 0, 32'd1);
    repeat (45) @(posedge clk);
    #1;

    // Reset in the middle of CALC
    launch(OP_DIV, 32'd100, 32'd7);
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    probe("midreset_busy", 0, 32'd0);
    probe("midreset_done", 1, 32'd0);
    probe("midreset_result", 2, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    do_op("rem_after_reset", OP_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, LAT_FULL);

    repeat (5) @(posedge clk);
    #1;
    end_req = 1'b1;
    repeat (10) @(posedge clk);
  end

endmodule
